seven_seg_scan_counter: RTL and testbench
=========================================

// Module: seven_seg_scan_counter
// PURPOSE
//   Parametrised multi-digit BCD up/down counter driving a time-multiplexed common 7-segment display.
//   Successor of the single-digit 1..9 display counter; it adds digit count, direction, load, pause,
//   leading-zero blanking and selectable segment/digit polarity.
//   Sits between board-level control inputs and the display pins.
// PARAMETERS
//   NUM_DIGITS     4         digits counted and scanned (1..8)
//   STEP_CYCLES    36000000  clk cycles per count step (3 s at 12 MHz); >=2
//   SCAN_CYCLES    12000     clk cycles each digit is lit (1 ms at 12 MHz); >=2
//   SEG_ACTIVE_LOW 0         1: seg/dp pins are driven low to light
//   DIG_ACTIVE_LOW 1         1: dig_en pins are driven low to select
//   BLANK_LZ       1         1: blank leading zeros (digit 0 is never blanked)
// PORTS
//   clk        in   1             system clock, 12 MHz
//   rst_n      in   1             asynchronous reset, active-low
//   en         in   1             1: count steps advance; 0: paused (scan continues)
//   up_dn      in   1             1: count up, 0: count down
//   load       in   1             1-cycle strobe: count <= load_val
//   load_val   in   4*NUM_DIGITS  BCD preset value, digit 0 in [3:0]
//   seg        out  7             segments {a,b,c,d,e,f,g}; seg[6]=a
//   dp         out  1             decimal point
//   dig_en     out  NUM_DIGITS    one-hot digit select; bit i = digit i
//   count_bcd  out  4*NUM_DIGITS  current count value in BCD
//   wrap       out  1             1-cycle pulse when the count wraps
// BEHAVIOUR
//   Reset (async, rst_n=0): count=0, step timer=0, scan index=0, wrap=0.
//     seg, dp and dig_en are all driven to their INACTIVE level per the polarity parameters.
//   Step timer: while en=1, counts 0..STEP_CYCLES-1.
//     At STEP_CYCLES-1 it returns to 0 and issues an internal step pulse.
//     en=0 holds the timer value; en is never a reset of the timer.
//   Count update, registered; priority load > step:
//     load=1: count <= load_val; any nibble >9 is stored as 9. Step timer clears to 0. No wrap pulse.
//     step, up_dn=1: BCD increment with ripple carry. 9..9 -> 0..0, wrap=1 for one cycle.
//     step, up_dn=0: BCD decrement with ripple borrow. 0..0 -> 9..9, wrap=1 for one cycle.
//   count_bcd reflects the new value the cycle after the load or step edge.
//   Scan timer: free-runs regardless of en, counting 0..SCAN_CYCLES-1.
//     At the terminal count, the scan index advances 0,1,..,NUM_DIGITS-1,0.
//   Output stage (registered, 1-cycle latency from the scan index and count):
//     seg, dp and dig_en update in the same cycle, so there is never a mixed digit/segment frame.
//     Decode, active-high form:
//       0=1111110  1=0110000  2=1101101  3=1111001  4=0110011
//       5=1011011  6=1011111  7=1110000  8=1111111  9=1111011
//     BLANK_LZ=1: digit i>0 is blanked (seg=0) when it and every higher digit are 0.
//     dp is lit only on digit 0, and only while en=0 (pause indicator).
//     Polarity inversion is applied after decode.
//   Simultaneous events:
//     load and step in the same cycle: load wins, the step is dropped.
//     A step in the same cycle as a scan advance: both take effect; the display shows the new
//       count on the next scan of each digit.
//   Mid-operation reset returns every output to its reset value in the same cycle rst_n falls;
//     counting resumes at 0 on the first clk edge after release.
// TESTING (bench params: NUM_DIGITS=2, STEP_CYCLES=4, SCAN_CYCLES=3)
//   1. Reset, then en=1, up_dn=1 for 40 cycles:
//        count_bcd = 00,01,..,0A never occurs (BCD only); one step every 4 cycles.
//   2. load_val=8'h98, load, en=1, up_dn=1:
//        99 then 00; wrap high exactly one cycle at 99->00.
//   3. load_val=8'h00, up_dn=0:
//        next step gives 99 with a wrap pulse; load_val=8'h3F loads as 39.
//   4. Scan check:
//        dig_en (DIG_ACTIVE_LOW=1) cycles 2'b10, 2'b01 every 3 cycles.
//        With count 05: the digit-1 slot is blank, and digit 0 shows 1011011.
//   5. en=0 for 20 cycles:
//        count and step timer frozen; dp lit during the digit-0 slot; scan keeps running.
//   6. Load asserted in the step cycle, and rst_n pulsed low mid-count:
//        load value wins; on reset all outputs go inactive immediately and count_bcd=00.

Source files
------------

// File: rtl/seven_seg_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_counter
// Description : Parametrised multi-digit BCD up/down counter driving a
//               time-multiplexed common 7-segment display. Supports load,
//               pause, leading-zero blanking and selectable pin polarity.
// Ports       :
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active-low
//   en         in   1: count steps advance; 0: paused (scan keeps running)
//   up_dn      in   1: count up, 0: count down
//   load       in   1-cycle strobe, count <= load_val (nibbles >9 stored as 9)
//   load_val   in   BCD preset, digit 0 in [3:0]
//   seg        out  segments {a,b,c,d,e,f,g}, seg[6]=a
//   dp         out  decimal point (pause indicator on digit 0)
//   dig_en     out  one-hot digit select, bit i = digit i
//   count_bcd  out  current count in BCD
//   wrap       out  1-cycle pulse when the count wraps
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_counter #(
  parameter int NUM_DIGITS     = 4,
  parameter int STEP_CYCLES    = 36000000,
  parameter int SCAN_CYCLES    = 12000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap
);

  localparam int C_CW     = 4 * NUM_DIGITS;
  localparam int C_STEP_W = $clog2(STEP_CYCLES);
  localparam int C_SCAN_W = $clog2(SCAN_CYCLES);
  localparam int C_IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [C_STEP_W-1:0]   C_STEP_LAST = C_STEP_W'(STEP_CYCLES - 1);
  localparam logic [C_SCAN_W-1:0]   C_SCAN_LAST = C_SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [C_IDX_W-1:0]    C_IDX_LAST  = C_IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            C_SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  C_DP_OFF    = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] C_DIG_OFF   = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                        : {NUM_DIGITS{1'b0}};

  // State registers and next-state values
  logic [C_STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [C_SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [C_IDX_W-1:0]    idx_q,      idx_d;
  logic [C_CW-1:0]       count_q,    count_d;
  logic                  wrap_q,     wrap_d;
  logic [6:0]            seg_q,      seg_d;
  logic                  dp_q,       dp_d;
  logic [NUM_DIGITS-1:0] dig_q,      dig_d;

  // Combinational helpers
  logic                  w_step;
  logic                  w_scan_tc;
  logic [C_CW-1:0]       w_load_sat;
  logic [C_CW-1:0]       w_inc;
  logic [C_CW-1:0]       w_dec;
  logic                  w_carry;
  logic                  w_borrow;
  logic [NUM_DIGITS-1:0] w_hi_zero;
  logic [3:0]            w_cur_digit;
  logic                  w_cur_blank;
  logic [6:0]            w_seg_raw;
  logic [NUM_DIGITS-1:0] w_dig_raw;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'b1111110;
      4'd1:    f_decode = 7'b0110000;
      4'd2:    f_decode = 7'b1101101;
      4'd3:    f_decode = 7'b1111001;
      4'd4:    f_decode = 7'b0110011;
      4'd5:    f_decode = 7'b1011011;
      4'd6:    f_decode = 7'b1011111;
      4'd7:    f_decode = 7'b1110000;
      4'd8:    f_decode = 7'b1111111;
      4'd9:    f_decode = 7'b1111011;
      default: f_decode = 7'b0000000;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Step timer: advances only while enabled; a load restarts the step period.
  // --------------------------------------------------------------------------
  assign w_step = en && (step_cnt_q == C_STEP_LAST);

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (load) begin
      step_cnt_d = '0;
    end else if (en) begin
      step_cnt_d = w_step ? '0 : step_cnt_q + C_STEP_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // BCD arithmetic. The carry/borrow left over after the last digit is set
  // only when every digit was 9 (up) or 0 (down), i.e. exactly a wrap.
  // --------------------------------------------------------------------------
  always_comb begin
    w_load_sat = '0;
    w_inc      = count_q;
    w_dec      = count_q;
    w_carry    = 1'b1;
    w_borrow   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
      if (w_carry) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          w_carry         = 1'b0;
        end
      end
      if (w_borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = w_load_sat;
    end else if (w_step) begin
      if (up_dn) begin
        count_d = w_inc;
        wrap_d  = w_carry;
      end else begin
        count_d = w_dec;
        wrap_d  = w_borrow;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scan timer and digit index, free-running independent of en.
  // --------------------------------------------------------------------------
  assign w_scan_tc = (scan_cnt_q == C_SCAN_LAST);

  always_comb begin
    scan_cnt_d = w_scan_tc ? '0 : scan_cnt_q + C_SCAN_W'(1);
    idx_d      = idx_q;
    if (w_scan_tc) begin
      idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + C_IDX_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Output stage. w_hi_zero[i] is set when digit i and all higher digits are
  // zero; digit 0 is never blanked so a zero count still shows "0".
  // --------------------------------------------------------------------------
  always_comb begin
    logic zero_acc;
    zero_acc = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc     = zero_acc && (count_q[4*i +: 4] == 4'd0);
      w_hi_zero[i] = zero_acc;
    end
  end

  always_comb begin
    w_cur_digit = 4'd0;
    w_cur_blank = 1'b0;
    w_dig_raw   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == C_IDX_W'(i)) begin
        w_cur_digit  = count_q[4*i +: 4];
        w_cur_blank  = (BLANK_LZ != 0) && (i > 0) && w_hi_zero[i];
        w_dig_raw[i] = 1'b1;
      end
    end
    w_seg_raw = w_cur_blank ? 7'b0000000 : f_decode(w_cur_digit);
    seg_d     = (SEG_ACTIVE_LOW != 0) ? ~w_seg_raw : w_seg_raw;
    dp_d      = ((idx_q == '0) && !en) ^ (SEG_ACTIVE_LOW != 0);
    dig_d     = (DIG_ACTIVE_LOW != 0) ? ~w_dig_raw : w_dig_raw;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      seg_q      <= C_SEG_OFF;
      dp_q       <= C_DP_OFF;
      dig_q      <= C_DIG_OFF;
    end else begin
      step_cnt_q <= step_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign dig_en    = dig_q;
  assign count_bcd = count_q;
  assign wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_counter
// Description : Self-checking bench for seven_seg_scan_counter with a
//               decimal-arithmetic reference model (2 digits, step 4, scan 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_counter;

  localparam int N    = 2;
  localparam int STEP = 4;
  localparam int SCAN = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [7:0]   load_val;
  logic [6:0]   seg;
  logic         dp;
  logic [1:0]   dig_en;
  logic [7:0]   count_bcd;
  logic         wrap;

  int checks = 0;
  int errors = 0;

  // Reference model state: count held as a plain decimal integer 0..99
  int         m_cnt;
  int         m_tmr;
  int         m_scnt;
  int         m_idx;
  logic       m_wrap;
  logic [6:0] m_seg;
  logic       m_dp;
  logic [1:0] m_dig;
  logic [6:0] seg_tbl [0:9];

  always #5 clk = ~clk;

  seven_seg_scan_counter #(
    .NUM_DIGITS     (N),
    .STEP_CYCLES    (STEP),
    .SCAN_CYCLES    (SCAN),
    .SEG_ACTIVE_LOW (0),
    .DIG_ACTIVE_LOW (1),
    .BLANK_LZ       (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .seg       (seg),
    .dp        (dp),
    .dig_en    (dig_en),
    .count_bcd (count_bcd),
    .wrap      (wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int sat_digit(input logic [3:0] n);
    return (n > 4'd9) ? 9 : int'(n);
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_tmr  = 0;
    m_scnt = 0;
    m_idx  = 0;
    m_wrap = 1'b0;
    m_seg  = 7'b0000000;
    m_dp   = 1'b0;
    m_dig  = 2'b11;
  endtask

  // One clock edge worth of behaviour, computed from the decimal count.
  task automatic model_edge();
    int  shown;
    bit  step;
    shown = (m_idx == 0) ? m_cnt : m_cnt / 10;
    m_seg = ((m_idx > 0) && (shown == 0)) ? 7'b0000000 : seg_tbl[shown % 10];
    m_dp  = (m_idx == 0) && !en;
    m_dig = ~(2'b01 << m_idx);

    step   = en && (m_tmr == STEP - 1);
    m_wrap = 1'b0;
    if (load) begin
      m_cnt = sat_digit(load_val[7:4]) * 10 + sat_digit(load_val[3:0]);
      m_tmr = 0;
    end else begin
      if (en) m_tmr = (m_tmr + 1) % STEP;
      if (step) begin
        if (up_dn) begin
          m_wrap = (m_cnt == 99);
          m_cnt  = (m_cnt + 1) % 100;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + 99) % 100;
        end
      end
    end

    if (m_scnt == SCAN - 1) begin
      m_scnt = 0;
      m_idx  = (m_idx + 1) % N;
    end else begin
      m_scnt++;
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".count"},  32'(count_bcd), 32'(to_bcd(m_cnt)));
    check({ph, ".wrap"},   32'(wrap),      32'(m_wrap));
    check({ph, ".seg"},    32'(seg),       32'(m_seg));
    check({ph, ".dp"},     32'(dp),        32'(m_dp));
    check({ph, ".dig_en"}, 32'(dig_en),    32'(m_dig));
  endtask

  // Inputs change only around the negative edge; model follows each posedge.
  task automatic tick(input string ph);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic run(input string ph, input int n);
    for (int k = 0; k < n; k++) tick(ph);
  endtask

  // Reset asserted mid-cycle; outputs must go inactive without a clock edge.
  task automatic do_reset(input string ph);
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_all({ph, ".async"});
    @(posedge clk);
    @(negedge clk);
    check_all({ph, ".held"});
    rst_n = 1'b1;
  endtask

  task automatic pulse_load(input string ph, input logic [7:0] v);
    load_val = v;
    load     = 1'b1;
    tick(ph);
    load     = 1'b0;
  endtask

  initial begin
    seg_tbl[0] = 7'b1111110; seg_tbl[1] = 7'b0110000;
    seg_tbl[2] = 7'b1101101; seg_tbl[3] = 7'b1111001;
    seg_tbl[4] = 7'b0110011; seg_tbl[5] = 7'b1011011;
    seg_tbl[6] = 7'b1011111; seg_tbl[7] = 7'b1110000;
    seg_tbl[8] = 7'b1111111; seg_tbl[9] = 7'b1111011;

    rst_n    = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 8'h00;
    model_reset();
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Count up from zero
    en = 1'b1; up_dn = 1'b1;
    run("up", 40);

    // Upward wrap 99 -> 00
    pulse_load("ld98", 8'h98);
    run("wrap_up", 12);

    // Downward wrap 00 -> 99, then saturating load
    pulse_load("ld00", 8'h00);
    up_dn = 1'b0;
    run("wrap_dn", 8);
    pulse_load("ld3F", 8'h3F);
    check("ld3F.sat", 32'(count_bcd), 32'h39);
    run("dn", 6);

    // Scan and blanking with a paused single-digit value
    en = 1'b0;
    pulse_load("ld05", 8'h05);
    run("pause", 20);
    check("pause.hold", 32'(count_bcd), 32'h05);

    // Load coinciding with a step: load wins
    en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < STEP && m_tmr != STEP - 1; k++) tick("align");
    check("align.tmr", 32'(m_tmr), 32'(STEP - 1));
    pulse_load("ldstep", 8'h42);
    check("ldstep.val", 32'(count_bcd), 32'h42);
    run("after_ld", 6);

    // Reset in the middle of counting
    run("pre_rst", 7);
    do_reset("rst_mid");
    run("post_rst", 10);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      en       = ($urandom_range(0, 7) != 0);
      up_dn    = $urandom_range(0, 1) != 0;
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        load = 1'b0;
        do_reset("rand_rst");
      end else begin
        tick("rand");
      end
    end
    load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
